// File: rtl/tdi_arb_pkg.sv
// Shared types and the round-robin search helper for the TDI stream arbiter.
package tdi_arb_pkg;

    localparam int TDI_ARB_MAX_CH = 16;
    localparam int TDI_ARB_IDX_W  = $clog2(TDI_ARB_MAX_CH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Unused upper request bits must be zero: skipping them over a 16-wide ring
    // is then equivalent to wrapping modulo the real channel count.
    function automatic logic [TDI_ARB_IDX_W-1:0] rr_next(
        input logic [TDI_ARB_MAX_CH-1:0] req,
        input logic [TDI_ARB_IDX_W-1:0]  last
    );
        logic [TDI_ARB_IDX_W-1:0] idx;
        rr_next = last;
        for (int k = TDI_ARB_MAX_CH; k >= 1; k--) begin
            idx = last + TDI_ARB_IDX_W'(k);
            if (req[idx]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot grant plus index, starting after last.
module rr_arbiter
    import tdi_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_vld
);

    logic [TDI_ARB_MAX_CH-1:0] req_pad;
    logic [TDI_ARB_IDX_W-1:0]  idx;

    assign req_pad = TDI_ARB_MAX_CH'(req);
    assign idx     = rr_next(req_pad, TDI_ARB_IDX_W'(last));
    assign gnt_vld = |req;
    assign gnt_idx = CH_W'(idx);
    assign gnt     = gnt_vld ? (NUM_CH'(1) << gnt_idx) : '0;

endmodule

// File: rtl/tdi_stream_arbiter.sv
// N-channel AXI-Stream packet arbiter with channel tagging and track framing.
// Define TDI_ARB_STATS_EN to add the per-channel completed-packet counters.
module tdi_stream_arbiter
    import tdi_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 512,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*DATA_W-1:0]   s_axis_tdata,
    input  logic [NUM_CH-1:0]          s_axis_tvalid,
    input  logic [NUM_CH-1:0]          s_axis_tlast,
    output logic [NUM_CH-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic [$clog2(NUM_CH)-1:0]  m_axis_tuser,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    input  logic                       fifo_prog_full,
    input  logic [NUM_CH-1:0]          ch_enable,
    input  logic [CNT_W-1:0]           track_pkt_num,
    output logic                       track_tlast,
    output logic                       busy
`ifdef TDI_ARB_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]    ch_pkt_cnt
`endif
);

    localparam int CH_W = $clog2(NUM_CH);

    arb_state_t        state;
    logic [CH_W-1:0]   grant;
    logic [NUM_CH-1:0] grant_oh;
    logic [CH_W-1:0]   last_grant;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] arb_gnt;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_vld;
    logic              pkt_done;
    logic [CNT_W-1:0]  track_cnt;

    assign req = ch_enable & s_axis_tvalid;

    rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr (
        .req     (req),
        .last    (last_grant),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Zero-latency data path while a packet holds the grant.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        if (state == LOCK) begin
            m_axis_tdata  = s_axis_tdata[grant*DATA_W +: DATA_W];
            m_axis_tuser  = grant;
            m_axis_tvalid = s_axis_tvalid[grant];
            m_axis_tlast  = s_axis_tlast[grant];
        end
    end

    assign s_axis_tready = (state == LOCK && m_axis_tready) ? grant_oh : '0;
    assign pkt_done      = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign busy          = (state == LOCK);

    // prog_full and ch_enable only gate new grants; a locked packet always completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            grant_oh   <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            case (state)
                IDLE: if (!fifo_prog_full && arb_vld) begin
                    grant    <= arb_idx;
                    grant_oh <= arb_gnt;
                    state    <= LOCK;
                end
                LOCK: if (pkt_done) begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // >= rather than == so a shrunk track length wraps at the next packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            track_cnt   <= '0;
            track_tlast <= 1'b0;
        end else begin
            track_tlast <= 1'b0;
            if (track_pkt_num == '0) begin
                track_cnt <= '0;
            end else if (pkt_done) begin
                if (track_cnt >= track_pkt_num - 1'b1) begin
                    track_cnt   <= '0;
                    track_tlast <= 1'b1;
                end else begin
                    track_cnt <= track_cnt + 1'b1;
                end
            end
        end
    end

`ifdef TDI_ARB_STATS_EN
    logic [NUM_CH-1:0][CNT_W-1:0] pkt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (pkt_done && grant_oh[i]) pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
        end
    end

    assign ch_pkt_cnt = pkt_cnt;
`endif

endmodule

// File: tb/tb_tdi_stream_arbiter.sv
// Scoreboard bench for tdi_stream_arbiter: random traffic against a packet-level RR model.
module tb_tdi_stream_arbiter;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_CH*DATA_W-1:0]  s_axis_tdata;
    logic [NUM_CH-1:0]         s_axis_tvalid;
    logic [NUM_CH-1:0]         s_axis_tlast;
    logic [NUM_CH-1:0]         s_axis_tready;
    logic [DATA_W-1:0]         m_axis_tdata;
    logic [CH_W-1:0]           m_axis_tuser;
    logic                      m_axis_tvalid;
    logic                      m_axis_tlast;
    logic                      m_axis_tready;
    logic                      fifo_prog_full;
    logic [NUM_CH-1:0]         ch_enable;
    logic [CNT_W-1:0]          track_pkt_num;
    logic                      track_tlast;
    logic                      busy;
`ifdef TDI_ARB_STATS_EN
    logic [NUM_CH*CNT_W-1:0]   ch_pkt_cnt;
`endif

    tdi_stream_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .fifo_prog_full (fifo_prog_full),
        .ch_enable      (ch_enable),
        .track_pkt_num  (track_pkt_num),
        .track_tlast    (track_tlast),
        .busy           (busy)
`ifdef TDI_ARB_STATS_EN
        ,
        .ch_pkt_cnt     (ch_pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [DATA_W-1:0] data; logic last;} beat_t;
    typedef struct {logic [DATA_W-1:0] data; logic [CH_W-1:0] user; logic last;} obeat_t;

    beat_t  src_q [NUM_CH][$];
    beat_t  mdl_q [NUM_CH][$];
    obeat_t exp_q [$];

    int n_chk = 0;
    int n_fail = 0;
    int mdl_last;
    int trk_cnt;
    int trk_pulses;
    int pkt_seen [NUM_CH];
    int tot_pkt  [NUM_CH];
    logic pulse_due;
    logic gap_en, rdy_rand, pf_rand, pf_force;
    logic [NUM_CH-1:0] in_pkt, fire;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic add_pkt(input int ch, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = $urandom;
            b.last = (k == len - 1);
            src_q[ch].push_back(b);
            mdl_q[ch].push_back(b);
        end
    endtask

    // Reference: whole packets, round robin over enabled channels with work queued.
    task automatic plan();
        int     nxt;
        int     c;
        beat_t  b;
        obeat_t o;
        forever begin
            nxt = -1;
            for (int k = 1; k <= NUM_CH; k++) begin
                c = (mdl_last + k) % NUM_CH;
                if (nxt < 0 && ch_enable[c] && mdl_q[c].size() > 0) nxt = c;
            end
            if (nxt < 0) break;
            do begin
                b = mdl_q[nxt].pop_front();
                o.data = b.data;
                o.user = CH_W'(nxt);
                o.last = b.last;
                exp_q.push_back(o);
            end while (!b.last);
            mdl_last = nxt;
        end
    endtask

    task automatic wait_drain(input string name, input int maxcyc);
        for (int k = 0; k < maxcyc; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check({"drain_", name}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_hs(input int ch, input string name);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready && m_axis_tuser == CH_W'(ch)) ok = 1'b1;
        end
        check({"handshake_", name}, 64'(ok), 64'd1);
    endtask

    // Source driver: updates one cycle's worth of beats just after each edge.
    initial begin
        s_axis_tvalid  = '0;
        s_axis_tdata   = '0;
        s_axis_tlast   = '0;
        m_axis_tready  = 1'b0;
        fifo_prog_full = 1'b0;
        in_pkt         = '0;
        forever begin
            @(negedge clk);
            fire = s_axis_tvalid & s_axis_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (fire[i] && rst_n && src_q[i].size() > 0) begin
                    in_pkt[i] = !src_q[i][0].last;
                    void'(src_q[i].pop_front());
                end
                if (!rst_n) in_pkt[i] = 1'b0;
                if (src_q[i].size() > 0) begin
                    s_axis_tdata[i*DATA_W +: DATA_W] = src_q[i][0].data;
                    s_axis_tlast[i]  = src_q[i][0].last;
                    s_axis_tvalid[i] = !(gap_en && in_pkt[i] && $urandom_range(3) == 0);
                end else begin
                    s_axis_tvalid[i] = 1'b0;
                    s_axis_tlast[i]  = 1'b0;
                end
            end
            m_axis_tready  = rdy_rand ? ($urandom_range(2) != 0) : 1'b1;
            fifo_prog_full = pf_force | (pf_rand && $urandom_range(3) == 0);
        end
    end

    // Monitor: pops the scoreboard on every accepted output beat.
    initial begin
        obeat_t e;
        pulse_due  = 1'b0;
        trk_pulses = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pulse_due = 1'b0;
                continue;
            end
            if (track_pkt_num == '0) trk_cnt = 0;
            check("track_tlast", 64'(track_tlast), 64'(pulse_due));
            if (track_tlast) trk_pulses++;
            pulse_due = 1'b0;
            if (m_axis_tvalid) check("valid_implies_busy", 64'(busy), 64'd1);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got data %0h user %0d, expected no beat",
                             m_axis_tdata, m_axis_tuser);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(m_axis_tdata), 64'(e.data));
                    check("beat_user", 64'(m_axis_tuser), 64'(e.user));
                    check("beat_last", 64'(m_axis_tlast), 64'(e.last));
                end
                if (m_axis_tlast) begin
                    pkt_seen[m_axis_tuser]++;
                    tot_pkt[m_axis_tuser]++;
                    if (track_pkt_num != '0) begin
                        trk_cnt++;
                        if (trk_cnt >= int'(track_pkt_num)) begin
                            trk_cnt   = 0;
                            pulse_due = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
        check({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, "_m_tlast"},  64'(m_axis_tlast),  64'd0);
        check({tag, "_m_tdata"},  64'(m_axis_tdata),  64'd0);
        check({tag, "_m_tuser"},  64'(m_axis_tuser),  64'd0);
        check({tag, "_track"},    64'(track_tlast),   64'd0);
        check({tag, "_busy"},     64'(busy),          64'd0);
`ifdef TDI_ARB_STATS_EN
        for (int i = 0; i < NUM_CH; i++)
            check({tag, "_stats"}, 64'(ch_pkt_cnt[i*CNT_W +: CNT_W]), 64'd0);
`endif
    endtask

    initial begin
        time t0, t1;
        int  pulses0;
        rst_n = 1'b0;
        ch_enable = '1;
        track_pkt_num = '0;
        gap_en = 1'b0; rdy_rand = 1'b0; pf_rand = 1'b0; pf_force = 1'b0;
        mdl_last = NUM_CH - 1;
        trk_cnt = 0;
        for (int i = 0; i < NUM_CH; i++) begin pkt_seen[i] = 0; tot_pkt[i] = 0; end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single packet: one bubble, then 4 beats tagged 2.
        add_pkt(2, 4);
        plan();
        t0 = 0; t1 = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (t0 == 0 && s_axis_tvalid[2]) t0 = $time;
            if (m_axis_tvalid && m_axis_tready) begin t1 = $time; break; end
        end
        check("bubble_cycles", 64'((t1 - t0) / 10), 64'd1);
        wait_drain("single", 40);
        @(negedge clk);
        check("idle_after_single", 64'(busy), 64'd0);

        // Fairness under random backpressure, gaps and prog_full.
        for (int i = 0; i < NUM_CH; i++) pkt_seen[i] = 0;
        gap_en = 1'b1; rdy_rand = 1'b1; pf_rand = 1'b1;
        for (int p = 0; p < 25; p++)
            for (int i = 0; i < NUM_CH; i++) add_pkt(i, 2);
        plan();
        wait_drain("fair", 3000);
        for (int i = 0; i < NUM_CH; i++) check("fair_count", 64'(pkt_seen[i]), 64'd25);
        gap_en = 1'b0; rdy_rand = 1'b0; pf_rand = 1'b0;
        repeat (3) @(negedge clk);

        // prog_full raised mid-packet: packet completes, no new grant until released.
        add_pkt(1, 4);
        plan();
        wait_hs(1, "pf_ch1_beat1");
        pf_force = 1'b1;
        add_pkt(3, 2);
        add_pkt(0, 2);
        plan();
        repeat (6) @(negedge clk);
        check("pf_pkt_finished", 64'(exp_q.size()), 64'd4);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("pf_no_grant", 64'(busy), 64'd0);
        end
        pf_force = 1'b0;
        wait_drain("pf", 100);
        repeat (3) @(negedge clk);

        // Track framing: length 3, then 0.
        track_pkt_num = 16'd3;
        pulses0 = trk_pulses;
        rdy_rand = 1'b1;
        for (int p = 0; p < 7; p++) add_pkt(p % NUM_CH, 1 + $urandom_range(2));
        plan();
        wait_drain("track7", 400);
        repeat (3) @(negedge clk);
        check("track_pulses_7", 64'(trk_pulses - pulses0), 64'd2);
        add_pkt(1, 2); add_pkt(2, 1);
        plan();
        wait_drain("track9", 200);
        repeat (3) @(negedge clk);
        check("track_pulses_9", 64'(trk_pulses - pulses0), 64'd3);
        track_pkt_num = '0;
        for (int p = 0; p < 5; p++) add_pkt(p % NUM_CH, 2);
        plan();
        wait_drain("track0", 300);
        repeat (3) @(negedge clk);
        check("track_pulses_off", 64'(trk_pulses - pulses0), 64'd3);

        // Enable mask: only 1 and 3 served, then the rest once re-enabled.
        ch_enable = 4'b1010;
        for (int i = 0; i < NUM_CH; i++) pkt_seen[i] = 0;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < NUM_CH; i++) add_pkt(i, 2);
        plan();
        wait_drain("mask", 400);
        repeat (4) @(negedge clk);
        check("mask_ch0", 64'(pkt_seen[0]), 64'd0);
        check("mask_ch2", 64'(pkt_seen[2]), 64'd0);
        check("mask_ch1", 64'(pkt_seen[1]), 64'd3);
        ch_enable = '1;
        plan();
        wait_drain("unmask", 400);
        check("unmask_ch0", 64'(pkt_seen[0]), 64'd3);
        check("unmask_ch2", 64'(pkt_seen[2]), 64'd3);
        rdy_rand = 1'b0;
        repeat (3) @(negedge clk);

        // Stats, then reset during beat 2 of a packet.
        for (int p = 0; p < 5; p++) add_pkt(0, 2);
        plan();
        wait_drain("stats", 200);
        repeat (3) @(negedge clk);
`ifdef TDI_ARB_STATS_EN
        for (int i = 0; i < NUM_CH; i++)
            check("stats_count", 64'(ch_pkt_cnt[i*CNT_W +: CNT_W]), 64'(tot_pkt[i] % 65536));
`endif
        add_pkt(0, 4);
        plan();
        wait_hs(0, "rst_ch0_beat1");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin src_q[i].delete(); mdl_q[i].delete(); tot_pkt[i] = 0; end
        exp_q.delete();
        mdl_last = NUM_CH - 1;
        trk_cnt = 0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        add_pkt(3, 2); add_pkt(1, 2); add_pkt(0, 2);
        plan();
        wait_hs(0, "post_rst_ch0_first");
        wait_drain("post_rst", 100);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
